// File: rtl/imm_issue_ctrl.sv
// Decode-stage controller for the immediate-generation datapath.
// Classifies the opcode, forms the immediate and the PC-relative target,
// and buffers decoded entries in a 2-entry skid buffer.
module imm_issue_ctrl #(
    parameter int unsigned CNT_W        = 8,
    parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_immsrc,
    output logic             out_illegal,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_target,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  src;
        logic        ill;
        logic [31:0] pc;
        logic [31:0] tgt;
    } entry_t;

    localparam entry_t ENTRY_RST = '{imm: '0, src: '0, ill: 1'b0,
                                     pc: RESET_PC_TAG, tgt: RESET_PC_TAG};

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [19:0] inx20;
    logic [11:0] inx12;
    logic        accept;
    logic        fire;

    assign in_ready = !rst && (state_q != S_FULL);
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;

    // Combinational decode of the incoming instruction into a buffer entry
    always_comb begin
        opcode  = in_instr[6:0];
        funct3  = in_instr[14:12];
        inx20   = in_instr[31:12];
        inx12   = in_instr[31:20];
        dec     = '0;
        dec.pc  = in_pc;
        case (opcode)
            7'b0110111, 7'b0010111: dec.src = 3'd0;
            7'b1101111:             dec.src = 3'd1;
            7'b0010011:             dec.src = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'd3 : 3'd2;
            7'b0000011, 7'b1100111: dec.src = 3'd4;
            7'b0100011: begin
                dec.src = 3'd5;
                inx12   = {in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec.src = 3'd6;
                inx12   = {in_instr[31], in_instr[30:25], in_instr[11:8], in_instr[7]};
            end
            default: begin
                dec.src = 3'd7;
                dec.ill = 1'b1;
            end
        endcase
        case (dec.src)
            3'd0:             dec.imm = {inx20, 12'b0};
            3'd1:             dec.imm = {{12{inx20[19]}}, inx20[7:0], inx20[8], inx20[18:9], 1'b0};
            3'd2, 3'd4, 3'd5: dec.imm = {{20{inx12[11]}}, inx12};
            3'd3:             dec.imm = {27'b0, inx12[4:0]};
            3'd6:             dec.imm = {{20{inx12[11]}}, inx12[0], inx12[10:5], inx12[4:1], 1'b0};
            default:          dec.imm = '0;
        endcase
        dec.tgt = in_pc + dec.imm;
    end

    // Skid-buffer next state, entry loads and illegal counter update
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            if (accept && dec.ill && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        main_d  = dec;
                    end
                end
                S_ONE: begin
                    if (accept && fire) begin
                        main_d = dec;
                    end else if (accept) begin
                        state_d = S_FULL;
                        skid_d  = dec;
                    end else if (fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (fire) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = (state_q != S_EMPTY);
    assign out_imm     = main_q.imm;
    assign out_immsrc  = main_q.src;
    assign out_illegal = main_q.ill;
    assign out_pc      = out_valid ? main_q.pc  : RESET_PC_TAG;
    assign out_target  = out_valid ? main_q.tgt : RESET_PC_TAG;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Self-checking bench for imm_issue_ctrl: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_imm_issue_ctrl;

    localparam int unsigned CNT_W = 2;
    localparam logic [31:0] TAG   = 32'hDEAD_BEE0;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]      in_instr, in_pc, out_imm, out_pc, out_target;
    logic [2:0]       out_immsrc;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    imm_issue_ctrl #(.CNT_W(CNT_W), .RESET_PC_TAG(TAG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_immsrc(out_immsrc), .out_illegal(out_illegal), .out_pc(out_pc),
        .out_target(out_target), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        int          src;
        bit          ill;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ref_t;

    ref_t mq[$];
    int   mcnt   = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference decode written from the standard ISA immediate layouts
    function automatic ref_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        ref_t r;
        logic [11:0] b12;
        logic [12:0] b13;
        logic [20:0] b21;
        r.ill = 1'b0;
        r.pc  = pc;
        case (w[6:0])
            7'h37, 7'h17: begin r.src = 0; r.imm = {w[31:12], 12'h000}; end
            7'h6F: begin
                r.src = 1;
                b21   = {w[31], w[19:12], w[20], w[30:21], 1'b0};
                r.imm = 32'($signed(b21));
            end
            7'h13: begin
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                    r.src = 3; r.imm = 32'(w[24:20]);
                end else begin
                    r.src = 2; b12 = w[31:20]; r.imm = 32'($signed(b12));
                end
            end
            7'h03, 7'h67: begin r.src = 4; b12 = w[31:20]; r.imm = 32'($signed(b12)); end
            7'h23: begin r.src = 5; b12 = {w[31:25], w[11:7]}; r.imm = 32'($signed(b12)); end
            7'h63: begin
                r.src = 6;
                b13   = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                r.imm = 32'($signed(b13));
            end
            default: begin r.src = 7; r.ill = 1'b1; r.imm = 32'd0; end
        endcase
        r.tgt = pc + r.imm;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Compare every DUT output against the model state
    task automatic compare();
        check("in_ready", 32'(in_ready), 32'(!rst && mq.size() < 2));
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
        if (mq.size() > 0) begin
            check("out_imm", out_imm, mq[0].imm);
            check("out_immsrc", 32'(out_immsrc), 32'(mq[0].src));
            check("out_illegal", 32'(out_illegal), 32'(mq[0].ill));
            check("out_pc", out_pc, mq[0].pc);
            check("out_target", out_target, mq[0].tgt);
        end else begin
            check("out_pc_empty", out_pc, TAG);
            check("out_target_empty", out_target, TAG);
        end
    endtask

    // Advance one clock with the current inputs, update the model, then check
    task automatic tick();
        bit   acc, fr;
        ref_t e;
        acc = in_valid && !rst && !flush && mq.size() < 2;
        fr  = out_ready && mq.size() > 0;
        e   = ref_decode(in_instr, in_pc);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (fr) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                if (e.ill && mcnt < SAT) mcnt++;
            end
        end
        #1;
        compare();
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] pc, input bit ordy);
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
    endtask

    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h7F};

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_immsrc", 32'(out_immsrc), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_pc", out_pc, TAG);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // I-type and shift immediates
        drive(1'b1, 32'hFFF00093, 32'h40, 1'b1); tick();
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_src", 32'(out_immsrc), 32'd2);
        drive(1'b1, 32'h4030D093, 32'h44, 1'b1); tick();
        check("srai_imm", out_imm, 32'h00000003);
        check("srai_src", 32'(out_immsrc), 32'd3);

        // Jump and branch targets
        drive(1'b1, 32'hFF9FF06F, 32'h100, 1'b1); tick();
        check("jal_imm", out_imm, 32'hFFFFFFF8);
        check("jal_target", out_target, 32'h000000F8);
        drive(1'b1, 32'h00000863, 32'h200, 1'b1); tick();
        check("beq_imm", out_imm, 32'h10);
        check("beq_target", out_target, 32'h210);

        // Store and upper immediates
        drive(1'b1, 32'hFE512E23, 32'h300, 1'b1); tick();
        check("sw_imm", out_imm, 32'hFFFFFFFC);
        check("sw_src", 32'(out_immsrc), 32'd5);
        drive(1'b1, 32'h123451B7, 32'h304, 1'b1); tick();
        check("lui_imm", out_imm, 32'h12345000);
        drive(1'b0, 32'd0, 32'd0, 1'b1); tick();

        // Back-pressure: A and B buffered, C held until the stall clears
        drive(1'b1, 32'h00100093, 32'hA00, 1'b0); tick();
        drive(1'b1, 32'h00200093, 32'hB00, 1'b0); tick();
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h00300093, 32'hC00, 1'b0); tick(); tick();
        check("stall_pc_A", out_pc, 32'hA00);
        out_ready = 1'b1; tick();
        check("drain_pc_B", out_pc, 32'hB00);
        tick();
        check("drain_pc_C", out_pc, 32'hC00);
        in_valid = 1'b0; tick();

        // Flush from FULL drops the same-cycle illegal accept
        drive(1'b1, 32'h00100093, 32'hD00, 1'b0); tick(); tick();
        drive(1'b1, 32'h0000007F, 32'hE00, 1'b0); flush = 1'b1; tick();
        flush = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("illegal_flag", 32'(out_illegal), 32'd1);
        check("illegal_imm", out_imm, 32'd0);

        // Counter saturation, then reset while FULL
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("cnt_saturated", 32'(illegal_cnt), 32'd3);
        out_ready = 1'b0; tick(); tick();
        rst = 1'b1; tick();
        check("rst_full_out_valid", 32'(out_valid), 32'd0);
        check("rst_full_cnt", 32'(illegal_cnt), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_full_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] w;
            w      = $urandom();
            w[6:0] = ops[$urandom_range(9)];
            if ($urandom_range(7) == 0) w = $urandom();
            drive(1'($urandom_range(3) != 0), w, $urandom(), 1'($urandom_range(2) != 0));
            flush = ($urandom_range(31) == 0);
            rst   = ($urandom_range(199) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_issue_ctrl.md
Name: imm_issue_ctrl

Overview:
Decode-stage controller that sequences the immediate-generation datapath.
- Accepts fetched instructions over a valid/ready handshake.
- Classifies each opcode into the 3-bit immediate-select code and slices the 20-bit and 12-bit immediate fields.
- Forms the sign-extended 32-bit immediate and the PC-relative target.
- Buffers results in a 2-entry skid buffer so in_ready is decoupled from out_ready.
- Sits between the fetch stage and the execute stage.

Parameters:
CNT_W, 8, width of the saturating illegal-instruction counter.
RESET_PC_TAG, 32'h0000_0000, value driven on out_pc and out_target while empty or in reset.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  controller can accept an instruction
in_instr  input  32  instruction word
in_pc  input  32  PC of in_instr
flush  input  1  synchronous pipeline flush
out_valid  output  1  decoded entry available
out_ready  input  1  execute consumes entry
out_imm  output  32  sign-extended immediate
out_immsrc  output  3  immediate-select code
out_illegal  output  1  opcode not recognised
out_pc  output  32  PC of entry
out_target  output  32  out_pc + out_imm
illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Handshakes: accept = in_valid & in_ready; fire = out_valid & out_ready.
- Opcode to immsrc:
  - 0110111 (lui) and 0010111 (auipc) -> 0.
  - 1101111 (jal) -> 1.
  - 0010011 with funct3 001 or 101 -> 3; 0010011 otherwise -> 2.
  - 0000011 (load) and 1100111 (jalr) -> 4.
  - 0100011 (store) -> 5.
  - 1100011 (branch) -> 6.
  - Anything else: illegal=1, immsrc=7, imm=0.
- Field slicing:
  - inx20 = instr[31:12].
  - I/shamt/load/jalr: inx12 = instr[31:20].
  - Store: inx12 = {instr[31:25], instr[11:7]}.
  - Branch: inx12 = {instr[31], instr[30:25], instr[11:8], instr[7]}.
- Immediate formation:
  - immsrc 0: {inx20, 12'b0}.
  - immsrc 1: {12{inx20[19]}, inx20[7:0], inx20[8], inx20[18:9], 1'b0}.
  - immsrc 2, 4, 5: sign-extend inx12.
  - immsrc 3: zero-extend inx12[4:0] (sign bit instr[31] is 0 for legal shifts).
  - immsrc 6: {20{inx12[11]}, inx12[0], inx12[10:5], inx12[4:1], 1'b0}.
- Target: out_target = out_pc + out_imm, 32-bit wrap-around, no overflow flag. It is computed for every entry; consumers use it for immsrc 0, 1, 6.
- Decode is combinational on in_instr and registered into the entry at accept.
- Latency: accept at edge N gives out_valid=1 in the cycle after edge N.
- Skid buffer states:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE, main loaded.
  - ONE: out_valid=1, in_ready=1.
    - accept & fire -> ONE, main reloaded from input.
    - accept & !fire -> FULL, skid loaded.
    - !accept & fire -> EMPTY.
    - neither -> ONE, hold.
  - FULL: in_ready=0. Fire -> ONE, main <- skid. Otherwise hold.
- in_ready is a function of state only, never of out_ready.
- Ordering is strictly FIFO.
- While out_valid=1 and !out_ready, all out_* fields hold stable.
- Flush:
  - Next state is EMPTY; out_valid=0 in the following cycle.
  - Any same-cycle accept is dropped and not counted.
  - Flush has priority over accept and fire.
  - illegal_cnt is not cleared.
- illegal_cnt:
  - Increments by 1 on each non-flushed accept with illegal=1.
  - Saturates at 2^CNT_W-1.
- Reset (rst high at an edge):
  - State goes to EMPTY; out_valid=0, out_imm=0, out_immsrc=0, out_illegal=0, illegal_cnt=0.
  - out_pc and out_target go to RESET_PC_TAG.
  - in_ready=0 while rst is high and 1 in the first cycle after release.
  - Reset in mid-operation discards both entries.
- Data registers update only on load; no X propagation from in_instr when not accepting.

Test Plan:
1. addi x1,x0,-1 (0xFFF00093) at pc 0x40, out_ready=1 -> next cycle out_valid=1, immsrc=2, imm=0xFFFFFFFF. Then srai x1,x1,3 (0x4030D093) -> immsrc=3, imm=0x00000003.
2. jal x0,-8 (0xFF9FF06F) at pc 0x100 -> immsrc=1, imm=0xFFFFFFF8, target=0x000000F8. Then beq x0,x0,+16 (0x00000863) at pc 0x200 -> immsrc=6, imm=0x10, target=0x210.
3. sw x5,-4(x2) (0xFE512E23) -> immsrc=5, imm=0xFFFFFFFC. Then lui x3,0x12345 (0x123451B7) -> immsrc=0, imm=0x12345000.
4. out_ready=0, stream A,B,C -> A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready -> outputs A, B, C in order, one per cycle, in_ready reasserts; fields stable while stalled.
5. FULL state, assert flush with in_valid=1 and an illegal opcode (0x0000007F) -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged. Same word accepted without flush -> out_illegal=1, imm=0, illegal_cnt+1.
6. CNT_W=2, five illegal accepts -> illegal_cnt=3. Assert rst while FULL -> all outputs at reset values next cycle, in_ready=1 after release.
